// File: rtl/os_array_ctrl_if.sv
// Array-side bundle of the systolic array sequencer: operand read strobes,
// skew masks, accumulator control and the result shift-out handshake.
interface os_array_ctrl_if #(
    parameter int row    = 3,
    parameter int column = 3,
    parameter int KW     = 8,
    parameter int CW     = (column > 1) ? $clog2(column) : 1
);
    logic              clr_acc;
    logic              rd_en;
    logic [KW-1:0]     rd_addr;
    logic [column-1:0] fmap_vld;
    logic [row-1:0]    kern_vld;
    logic              Op_sel;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_col;

    modport master (
        output clr_acc, rd_en, rd_addr, fmap_vld, kern_vld, Op_sel, out_valid, out_col,
        input  out_ready
    );

    modport slave (
        input  clr_acc, rd_en, rd_addr, fmap_vld, kern_vld, Op_sel, out_valid, out_col,
        output out_ready
    );
endinterface

// File: rtl/os_array_ctrl.sv
// Tile sequencer for the output-stationary systolic array: clear, feed K
// operand words with diagonal skew, flush the pipeline, shift results out.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start with a non-zero k_len
// S_CLEAR | one cycle of accumulator clear
// S_FEED  | K operand reads, rd_addr 0..K-1
// S_FLUSH | row+column cycles for skew, read latency and MAC register
// S_DRAIN | result words shifted out under out_valid/out_ready
// S_DONE  | one-cycle done pulse
module os_array_ctrl #(
    parameter int row    = 3,
    parameter int column = 3,
    parameter int KW     = 8,
    parameter int CW     = (column > 1) ? $clog2(column) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] k_len,
    output logic          busy,
    output logic          done,
    os_array_ctrl_if.master arr
);
    localparam int FL = row + column;
    localparam int NW = (KW > $clog2(FL + 1)) ? KW : $clog2(FL + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     out_col_q, out_col_d;
    logic [KW-1:0]     rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              clr_acc_q, clr_acc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;
    logic [column-1:0] fmap_q, fmap_d;
    logic [row-1:0]    kern_q, kern_d;
    logic              xfer;

    // Op_sel stays combinational so the array shifts on exactly the transfer cycle
    assign xfer          = (state_q == S_DRAIN) && arr.out_ready;
    assign arr.Op_sel    = xfer;
    assign arr.clr_acc   = clr_acc_q;
    assign arr.rd_en     = rd_en_q;
    assign arr.rd_addr   = rd_addr_q;
    assign arr.fmap_vld  = fmap_q;
    assign arr.kern_vld  = kern_q;
    assign arr.out_valid = out_valid_q;
    assign arr.out_col   = out_col_q;
    assign busy          = busy_q;
    assign done          = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            out_col_q   <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            clr_acc_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            fmap_q      <= '0;
            kern_q      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            out_col_q   <= out_col_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            clr_acc_q   <= clr_acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            fmap_q      <= fmap_d;
            kern_q      <= kern_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        out_col_d = out_col_q;

        case (state_q)
            S_IDLE: begin
                if (start && (k_len != '0)) begin
                    state_d = S_CLEAR;
                    k_d     = k_len;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = NW'(k_q) - NW'(1);
            end
            S_FEED: begin
                if (cnt_q == '0) begin
                    state_d = S_FLUSH;
                    cnt_d   = NW'(FL - 1);
                end else begin
                    cnt_d = cnt_q - NW'(1);
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d   = S_DRAIN;
                    out_col_d = CW'(column - 1);
                end else begin
                    cnt_d = cnt_q - NW'(1);
                end
            end
            S_DRAIN: begin
                if (xfer) begin
                    if (out_col_q == '0) state_d = S_DONE;
                    else                 out_col_d = out_col_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            out_col_d = '0;
        end

        // Outputs are registered from the next state so they line up with it
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        clr_acc_d   = (state_d == S_CLEAR);
        rd_en_d     = (state_d == S_FEED);
        out_valid_d = (state_d == S_DRAIN);
        rd_addr_d   = '0;
        if (rd_en_d && (state_q == S_FEED)) rd_addr_d = rd_addr_q + KW'(1);

        // Skew lines: bit i is rd_en delayed by i+1 cycles
        fmap_d = abort ? '0 : column'({fmap_q, rd_en_q});
        kern_d = abort ? '0 : row'({kern_q, rd_en_q});
    end
endmodule

// File: doc/os_array_ctrl.md
# os_array_ctrl

Sequencing controller for the output-stationary systolic array built from `OS_PE_column`/`OS_PE_row`. It runs one tile per `start`: it clears the accumulators, reads K operand words from the fmap and kernel buffers, and generates the diagonal skew masks for the array edges. It then waits for the array pipeline to flush and drives `Op_sel` to shift results out of the Result chain under a valid/ready handshake. It sits between the tile scheduler and the array plus its operand buffers.

## Interface
Parameters:
- `row`, 3, PE rows; one kernel lane and one result lane per row.
- `column`, 3, PE columns; one fmap lane per column.
- `KW`, 8, width of `k_len` and `rd_addr`.
- `CW`, `$clog2(column)` (minimum 1), width of `out_col`.

Ports:
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  tile request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; effective in every state.
- `k_len`  in  KW  reduction length K, latched when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a tile.
- `clr_acc`  out  1  synchronous accumulator clear to the array.
- `rd_en`  out  1  operand buffer read strobe.
- `rd_addr`  out  KW  operand buffer address, 0..K-1.
- `fmap_vld`  out  column  per-column fmap lane valid (skewed).
- `kern_vld`  out  row  per-row kernel lane valid (skewed).
- `Op_sel`  out  1  array mode: 0 = accumulate, 1 = shift results.
- `out_valid`  out  1  a result word is present on every `Result_out` lane.
- `out_ready`  in  1  the downstream sink accepts the result word.
- `out_col`  out  CW  column index of the result word currently presented.

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - `start`=1 with `k_len`≠0 latches K and moves to CLEAR.
  - `start` with `k_len`=0 is ignored; the FSM stays in IDLE.
- CLEAR: one cycle, `clr_acc`=1, then FEED.
- FEED: K cycles with `rd_en`=1; `rd_addr` runs 0..K-1 in steps of 1, then FLUSH.
- Skew masks:
  - `fmap_vld[i]` is `rd_en` delayed by i+1 cycles.
  - `kern_vld[j]` is `rd_en` delayed by j+1 cycles.
  - The extra cycle matches the buffer read latency.
  - Delay lines are shift registers that keep running through FLUSH.
- FLUSH: exactly row+column cycles, covering a skew of row+column-2, the read latency and the MAC register. Then DRAIN.
- DRAIN:
  - `out_valid`=1 throughout.
  - `Op_sel`=`out_ready`, combinational; the array shifts only on cycles where a transfer occurs.
  - A transfer is `out_valid`&`out_ready`.
  - `out_col` starts at column-1 and decrements once per transfer.
  - After the column-th transfer the FSM moves to DONE.
  - While `out_ready`=0, state, `out_col` and the array hold.
- DONE: `done`=1 for one cycle, then IDLE.
- Outside DRAIN, `Op_sel`=0 and `out_valid`=0.
- `abort`=1:
  - The next state is IDLE.
  - The skew delay lines, counters and `out_col` clear on the same edge.
  - `done` is not pulsed.
- `abort` and `start` together in IDLE: abort wins and the FSM stays in IDLE.
- `start` while `busy`=1 is ignored.
- `rst` low: immediate return to IDLE; all registers clear.
- Every output resets to 0. `Op_sel` resets to 0 because it is gated by DRAIN.

## Timing
- Cycle n is the n-th rising edge after the edge that accepts `start` (that edge is cycle 0).
- All outputs are registered except `Op_sel`, which is derived combinationally from the state and `out_ready`.

| Phase | Cycles |
|---|---|
| CLEAR | 1 |
| FEED | 2..K+1 |
| FLUSH | K+2..K+row+column+1 |
| DRAIN (`out_ready` held high) | K+row+column+2 .. K+row+2·column+1 |
| `done` | K+row+2·column+2 |
| back in IDLE | K+row+2·column+3 |

- `fmap_vld[i]` is high during cycles 3+i..K+2+i.
- Each DRAIN stall cycle delays DRAIN completion, and everything after it, by exactly one cycle.
- A new `start` is accepted no earlier than the first IDLE cycle after `done`.

## Test plan
- Reset, with `rst` asserted mid-FEED → all outputs read 0, `busy`=0, and no `done` pulse follows.
- row=column=3, K=4, `out_ready`=1 → the following, and `busy` deasserts at cycle 16:
  - `clr_acc` at cycle 1.
  - `rd_addr` 0,1,2,3 at cycles 2-5.
  - `fmap_vld[2]` high at cycles 5-8 and `kern_vld[1]` high at cycles 4-7.
  - `Op_sel`/`out_valid` high at cycles 12-14, with `out_col` 2,1,0.
  - `done` at cycle 15.
- Same configuration, with `out_ready`=0 at cycles 12 and 13 → `out_valid`=1 and `Op_sel`=0 during the stall, `out_col` holds 2, and `done` moves to cycle 17.
- `start` with `k_len`=0, and `start` pulsed during FEED → both ignored: no state change and no extra `rd_en`.
- `abort` at cycle 7 (FLUSH) → IDLE at cycle 8 with all `fmap_vld`/`kern_vld` cleared and no `done`; a fresh `start` with K=1 then completes with `done` at cycle 1+3+6+2=12 after acceptance.
- K=255 (`k_len` at its maximum) → `rd_addr` reaches 254 with no wrap, and `done` arrives at cycle 255+3+6+2=266.
